download_tx: RTL and testbench

Memory dump transmitter, the outbound counterpart of the program upload receiver. On a start pulse it streams a byte-addressed region of RAM out over a UART line. The frame is a 4-byte little-endian length header, then the data bytes, then an XOR checksum byte. It sits beside the upload receiver in the top level, shares the RAM's byte read path while the core is stalled, and drives its own TX pin.

---
 rtl/download_tx.sv | 213 +++++++++++++++++++++
 tb/tb_download_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/download_tx.sv
// download_tx: memory dump transmitter. Streams a RAM region over a UART
// line as a frame: 4-byte little-endian length header, data bytes, XOR
// checksum byte.
// Latency: the first start bit is on tx the cycle after start is accepted.
// done pulses the cycle after the last stop bit ends.
// Backpressure: none. start is dropped while busy, and also in the done
// cycle. RAM reads are paced by a 1-entry holding register, so at most one
// rd_en is outstanding.
// Ports:
//   clk, reset          : clock, async active-high reset
//   start               : 1-cycle request; base_addr/length sampled on accept
//   rd_en/rd_addr       : byte read strobe/address to RAM
//   rd_data             : RAM byte, valid the cycle after rd_en
//   tx                  : UART line (idle high)
//   busy/done           : transfer in progress / 1-cycle completion pulse
module download_tx #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] length,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DRAIN
  } state_t;

  // Controller state
  state_t      state;
  logic [31:0] len_q;
  logic [31:0] addr_q;
  logic [31:0] remaining;
  logic [1:0]  hdr_idx;
  logic [7:0]  csum;
  logic        rd_wait;

  // 1-entry holding register between controller and serializer
  logic        hold_vld;
  logic [7:0]  hold_dat;

  // Serializer
  logic             ser_active;
  logic [9:0]       shreg;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] clk_cnt;

  logic       accept;
  logic       frame_end;
  logic       ser_load;
  logic [7:0] ser_byte;

  // A start in the done cycle is dropped: state is already IDLE, but the
  // previous transfer is only just finishing.
  assign accept    = start && (state == IDLE) && !done;
  assign frame_end = ser_active && (clk_cnt == BIT_LAST) && (bit_cnt == 4'd9);

  // The first header byte bypasses the holding register.
  // This lets tx fall the cycle after accept. Every later byte loads from
  // the holding register exactly at the end of the previous stop bit, so
  // frames are back-to-back.
  assign ser_load = accept || (frame_end && hold_vld);
  assign ser_byte = accept ? length[7:0] : hold_dat;

  // Controller FSM: fills the holding register and issues RAM reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      remaining <= '0;
      hdr_idx   <= '0;
      csum      <= '0;
      rd_wait   <= 1'b0;
      hold_vld  <= 1'b0;
      hold_dat  <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;

      // A load only happens while the register is full.
      // Refills below only happen while it is empty, so these writes
      // never collide.
      if (ser_load && !accept) begin
        hold_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            len_q     <= length;
            addr_q    <= base_addr;
            remaining <= length;
            csum      <= '0;
            hdr_idx   <= 2'd1;
            busy      <= 1'b1;
            state     <= HDR;
          end
        end

        HDR: begin
          if (!hold_vld) begin
            case (hdr_idx)
              2'd1:    hold_dat <= len_q[15:8];
              2'd2:    hold_dat <= len_q[23:16];
              2'd3:    hold_dat <= len_q[31:24];
              default: hold_dat <= len_q[7:0];
            endcase
            hold_vld <= 1'b1;
            hdr_idx  <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              state <= (len_q != '0) ? DATA : CSUM;
            end
          end
        end

        DATA: begin
          // Three-phase read: strobe, wait for RAM, capture.
          // A new read is only issued once the holding register is empty.
          if (rd_en) begin
            rd_wait <= 1'b1;
          end else if (rd_wait) begin
            hold_dat <= rd_data;
            hold_vld <= 1'b1;
            csum     <= csum ^ rd_data;
            rd_wait  <= 1'b0;
            if (remaining == '0) begin
              state <= CSUM;
            end
          end else if (!hold_vld) begin
            rd_en     <= 1'b1;
            rd_addr   <= addr_q;
            addr_q    <= addr_q + 32'd1;
            remaining <= remaining - 32'd1;
          end
        end

        CSUM: begin
          if (!hold_vld) begin
            hold_dat <= csum;
            hold_vld <= 1'b1;
            state    <= DRAIN;
          end
        end

        DRAIN: begin
          // The checksum byte is consumed at the preceding frame end.
          // The next frame end with an empty holding register is therefore
          // the last stop bit.
          if (frame_end && !hold_vld) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Serializer: 10-bit frame, LSB first, CLKS_PER_BIT cycles per bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_active <= 1'b0;
      shreg      <= '1;
      bit_cnt    <= '0;
      clk_cnt    <= '0;
      tx         <= 1'b1;
    end else if (ser_load) begin
      shreg      <= {1'b1, ser_byte, 1'b0};
      tx         <= 1'b0;
      bit_cnt    <= '0;
      clk_cnt    <= '0;
      ser_active <= 1'b1;
    end else if (ser_active) begin
      if (clk_cnt == BIT_LAST) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          ser_active <= 1'b0;
          tx         <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
          tx      <= shreg[1];
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_download_tx.sv
// Testbench for download_tx: a behavioural UART receiver and RAM model.
// Each transfer is checked against the expected byte stream: header,
// data and XOR checksum.
// Timing, read addresses, done/busy behaviour and reset are also checked.
module tb_download_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] length = '0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        tx;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  download_tx #(.CLK_HZ(16), .BAUD_RATE(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: explicit entries override a salted address hash
  logic [7:0] mem [logic [31:0]];
  logic [7:0] salt = 8'h00;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A ^ salt;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= ram_byte(rd_addr);

  // Free-running cycle counter plus observation logs
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_q[$];
  int done_cnt = 0, busy_cnt = 0, bad_rd = 0;
  bit prev_rd = 1'b0;
  always @(negedge clk) begin
    if (rd_en) begin
      rd_q.push_back(rd_addr);
      if (prev_rd || !busy) bad_rd++;
    end
    prev_rd = rd_en;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  // UART receiver: samples at bit centres, logs byte, framing and start cycle
  logic [7:0]  mon_q[$];
  bit          ok_q[$];
  int unsigned st_q[$];
  initial begin
    logic [7:0]  b;
    bit          ok;
    int unsigned st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        ok = (tx === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        ok = ok && (tx === 1'b1);
        mon_q.push_back(b);
        ok_q.push_back(ok);
        st_q.push_back(st);
      end
    end
  end

  // Expected line content from the frame rules
  logic [7:0] exp_q[$];
  task automatic build_expect(input logic [31:0] base, input logic [31:0] len);
    logic [7:0] x;
    logic [31:0] a;
    exp_q.delete();
    x = 8'h00;
    exp_q.push_back(len[7:0]);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[23:16]);
    exp_q.push_back(len[31:24]);
    for (int i = 0; i < int'(len); i++) begin
      a = base + 32'(i);
      exp_q.push_back(ram_byte(a));
      x = x ^ ram_byte(a);
    end
    exp_q.push_back(x);
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [31:0] len, input bit mid_start);
    int unsigned t1;
    int n, total;
    logic [31:0] a;
    build_expect(base, len);
    total = (int'(len) + 5) * FRAME;
    mon_q.delete(); ok_q.delete(); st_q.delete(); rd_q.delete();
    done_cnt = 0; busy_cnt = 0; bad_rd = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; length = len;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; length = $urandom;
    t1 = cyc;
    check("busy_after_accept", busy, 1'b1);
    check("tx_first_start_bit", tx, 1'b0);
    n = 1;
    while (!done && n < total + 100) begin
      start = mid_start && (n == 300);
      if (start) begin base_addr = base + 32'h1000; length = len + 3; end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("done_cycle", n, total + 1);
    check("busy_low_at_done", busy, 1'b0);
    // A start coinciding with done must be dropped
    start = 1'b1; base_addr = base; length = len;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_dropped", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, total);
    check("tx_idle_after", tx, 1'b1);
    check("byte_count", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < mon_q.size()) begin
        check("line_byte", mon_q[i], exp_q[i]);
        check("framing", ok_q[i], 1'b1);
        if (i == 0) check("first_start_cycle", st_q[0], t1);
        else check("frame_gap", st_q[i] - st_q[i-1], FRAME);
      end
    end
    check("rd_count", rd_q.size(), len);
    for (int i = 0; i < rd_q.size(); i++) begin
      a = base + 32'(i);
      check("rd_addr", rd_q[i], a);
    end
    check("rd_protocol", bad_rd, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Basic dump
    mem[32'h100] = 8'hA5; mem[32'h101] = 8'h3C; mem[32'h102] = 8'hFF;
    run_xfer(32'h100, 32'd3, 1'b0);
    if (mon_q.size() == 8) check("basic_csum", mon_q[7], 8'h66);
    else check("basic_size", mon_q.size(), 8);

    // Zero length
    run_xfer(32'h40, 32'd0, 1'b0);

    // Address wrap
    salt = 8'h33;
    run_xfer(32'hFFFF_FFFE, 32'd4, 1'b0);

    // Start while busy
    run_xfer(32'h200, 32'd4, 1'b1);

    // Reset during data bit 3 of header byte 1
    mon_q.delete(); done_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h100; length = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (FRAME + 4 * CPB + CPB / 2) @(negedge clk);
    check("pre_reset_tx_low", tx, 1'b0);
    #3 reset = 1'b1;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (FRAME + 40) @(negedge clk);
    check("no_done_after_reset", done_cnt, 0);
    run_xfer(32'h100, 32'd3, 1'b0);

    // Randomized transfers
    for (int r = 0; r < 6; r++) begin
      salt = 8'($urandom);
      run_xfer($urandom, 32'($urandom_range(1, 6)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
